// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard controller slice.
//   - Set-2 prefix / modifier scan codes and the protocol bytes that are dropped
//   - Sequencer state encoding
//   - Bit positions inside the 4-bit modifier vector {caps, alt, ctrl, shift}
package ps2_pkg;

  localparam logic [7:0] PFX_EXT   = 8'hE0;
  localparam logic [7:0] PFX_BRK   = 8'hF0;
  localparam logic [7:0] PFX_PAUSE = 8'hE1;

  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_ALT    = 8'h11;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  // Protocol / status bytes that never become key events
  localparam logic [7:0] SC_NUL     = 8'h00;
  localparam logic [7:0] SC_BAT_OK  = 8'hAA;
  localparam logic [7:0] SC_ECHO    = 8'hEE;
  localparam logic [7:0] SC_ACK     = 8'hFA;
  localparam logic [7:0] SC_BAT_ERR = 8'hFC;
  localparam logic [7:0] SC_DIAG    = 8'hFD;
  localparam logic [7:0] SC_RESEND  = 8'hFE;
  localparam logic [7:0] SC_ERR     = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    POP,
    GAP,
    EMIT
  } state_e;

  localparam int unsigned MOD_SHIFT = 0;
  localparam int unsigned MOD_CTRL  = 1;
  localparam int unsigned MOD_ALT   = 2;
  localparam int unsigned MOD_CAPS  = 3;

  function automatic logic is_drop(input logic [7:0] b);
    case (b)
      SC_NUL, SC_BAT_OK, SC_ECHO, SC_ACK,
      SC_BAT_ERR, SC_DIAG, SC_RESEND, SC_ERR: is_drop = 1'b1;
      default:                                is_drop = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ps2_mod_tracker.sv
// Modifier-key state tracker.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   code_i       scan code with prefixes stripped
//   ext_i        code was preceded by E0
//   brk_i        code is a release (preceded by F0)
//   strobe_i     apply code_i/ext_i/brk_i this cycle
//   mods_o       current {caps, alt, ctrl, shift}
//   mods_nxt_o   {caps, alt, ctrl, shift} as they will be after this strobe
module ps2_mod_tracker
  import ps2_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] code_i,
  input  logic       ext_i,
  input  logic       brk_i,
  input  logic       strobe_i,
  output logic [3:0] mods_o,
  output logic [3:0] mods_nxt_o
);

  logic lsh_q, rsh_q, lctl_q, rctl_q, lalt_q, ralt_q, caps_q, caps_down_q;
  logic lsh_d, rsh_d, lctl_d, rctl_d, lalt_d, ralt_d, caps_d, caps_down_d;
  logic make;

  always_comb begin
    lsh_d       = lsh_q;
    rsh_d       = rsh_q;
    lctl_d      = lctl_q;
    rctl_d      = rctl_q;
    lalt_d      = lalt_q;
    ralt_d      = ralt_q;
    caps_d      = caps_q;
    caps_down_d = caps_down_q;
    make        = !brk_i;
    if (strobe_i) begin
      if (code_i == SC_LSHIFT && !ext_i) lsh_d = make;
      if (code_i == SC_RSHIFT && !ext_i) rsh_d = make;
      if (code_i == SC_CTRL) begin
        if (ext_i) rctl_d = make;
        else       lctl_d = make;
      end
      if (code_i == SC_ALT) begin
        if (ext_i) ralt_d = make;
        else       lalt_d = make;
      end
      if (code_i == SC_CAPS) begin
        // caps_down masks typematic repeats so only the first make toggles
        if (make && !caps_down_q) caps_d = !caps_q;
        caps_down_d = make;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lsh_q       <= 1'b0;
      rsh_q       <= 1'b0;
      lctl_q      <= 1'b0;
      rctl_q      <= 1'b0;
      lalt_q      <= 1'b0;
      ralt_q      <= 1'b0;
      caps_q      <= 1'b0;
      caps_down_q <= 1'b0;
    end else begin
      lsh_q       <= lsh_d;
      rsh_q       <= rsh_d;
      lctl_q      <= lctl_d;
      rctl_q      <= rctl_d;
      lalt_q      <= lalt_d;
      ralt_q      <= ralt_d;
      caps_q      <= caps_d;
      caps_down_q <= caps_down_d;
    end
  end

  always_comb begin
    mods_o                = '0;
    mods_o[MOD_SHIFT]     = lsh_q | rsh_q;
    mods_o[MOD_CTRL]      = lctl_q | rctl_q;
    mods_o[MOD_ALT]       = lalt_q | ralt_q;
    mods_o[MOD_CAPS]      = caps_q;
    mods_nxt_o            = '0;
    mods_nxt_o[MOD_SHIFT] = lsh_d | rsh_d;
    mods_nxt_o[MOD_CTRL]  = lctl_d | rctl_d;
    mods_nxt_o[MOD_ALT]   = lalt_d | ralt_d;
    mods_nxt_o[MOD_CAPS]  = caps_d;
  end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard scan-code sequencer: pops Set-2 bytes from the receiver FIFO,
// strips E0/F0/E1 prefixes, drops protocol bytes, tracks modifiers and
// presents one key event at a time through a valid/ack register.
// Ports:
//   clk, clrn            clock, asynchronous active-low reset
//   kbd_ready/kbd_data   FIFO not-empty flag and head byte
//   kbd_overflow         FIFO overflow flag
//   kbd_rdn              FIFO read strobe, active low
//   evt_valid/evt_ack    event handshake to the CPU
//   evt_code/ext/brk     decoded key event
//   evt_mods             {caps, alt, ctrl, shift} after this event
//   ovf_sticky/ovf_clr   sticky overflow flag and its clear
module ps2_kbd_ctrl
  import ps2_pkg::*;
#(
  parameter int unsigned PAUSE_SKIP = 7,
  parameter logic [7:0]  PAUSE_CODE = 8'hE1
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       kbd_ready,
  input  logic [7:0] kbd_data,
  input  logic       kbd_overflow,
  output logic       kbd_rdn,
  output logic       evt_valid,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_brk,
  output logic [3:0] evt_mods,
  input  logic       evt_ack,
  output logic       ovf_sticky,
  input  logic       ovf_clr
);

  localparam int unsigned SKW = $clog2(PAUSE_SKIP + 1);

  state_e         state_q;
  logic [7:0]     byte_q;
  logic           ext_f_q, brk_f_q;
  logic [SKW-1:0] skip_q;
  logic           ovf_prev_q;
  logic           rdn_q;
  logic           evt_valid_q, evt_ext_q, evt_brk_q, ovf_q;
  logic [7:0]     evt_code_q;
  logic [3:0]     evt_mods_q;

  logic           key_byte, trk_strobe;
  logic [3:0]     trk_mods, trk_mods_nxt;

  // A byte becomes a key event only if no earlier parse rule claims it
  always_comb begin
    key_byte = (skip_q == '0) &&
               (byte_q != PFX_PAUSE) && (byte_q != PFX_EXT) && (byte_q != PFX_BRK) &&
               !is_drop(byte_q) &&
               !(ext_f_q && (byte_q == SC_LSHIFT || byte_q == SC_RSHIFT));
    trk_strobe = (state_q == GAP) && key_byte;
  end

  ps2_mod_tracker u_mods (
    .clk        (clk),
    .rst_n      (clrn),
    .code_i     (byte_q),
    .ext_i      (ext_f_q),
    .brk_i      (brk_f_q),
    .strobe_i   (trk_strobe),
    .mods_o     (trk_mods),
    .mods_nxt_o (trk_mods_nxt)
  );

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q     <= IDLE;
      byte_q      <= '0;
      ext_f_q     <= 1'b0;
      brk_f_q     <= 1'b0;
      skip_q      <= '0;
      ovf_prev_q  <= 1'b0;
      rdn_q       <= 1'b1;
      evt_valid_q <= 1'b0;
      evt_code_q  <= '0;
      evt_ext_q   <= 1'b0;
      evt_brk_q   <= 1'b0;
      evt_mods_q  <= '0;
      ovf_q       <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (kbd_ready && !evt_valid_q) begin
            state_q <= POP;
            rdn_q   <= 1'b0;
          end
        end
        POP: begin
          byte_q  <= kbd_data;
          rdn_q   <= 1'b1;
          state_q <= GAP;
        end
        GAP: begin
          state_q <= IDLE;
          if (skip_q != '0) begin
            skip_q <= skip_q - SKW'(1);
            if (skip_q == SKW'(1)) begin
              evt_code_q  <= PAUSE_CODE;
              evt_ext_q   <= 1'b0;
              evt_brk_q   <= 1'b0;
              evt_mods_q  <= trk_mods;
              evt_valid_q <= 1'b1;
              state_q     <= EMIT;
            end
          end else if (byte_q == PFX_PAUSE) begin
            skip_q  <= SKW'(PAUSE_SKIP);
            ext_f_q <= 1'b0;
            brk_f_q <= 1'b0;
          end else if (byte_q == PFX_EXT) begin
            ext_f_q <= 1'b1;
          end else if (byte_q == PFX_BRK) begin
            brk_f_q <= 1'b1;
          end else begin
            ext_f_q <= 1'b0;
            brk_f_q <= 1'b0;
            if (key_byte) begin
              evt_code_q  <= byte_q;
              evt_ext_q   <= ext_f_q;
              evt_brk_q   <= brk_f_q;
              evt_mods_q  <= trk_mods_nxt;
              evt_valid_q <= 1'b1;
              state_q     <= EMIT;
            end
          end
        end
        EMIT: begin
          if (evt_ack) begin
            evt_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      // Overflow resync placed last so it overrides any prefix set by GAP this cycle
      ovf_prev_q <= kbd_overflow;
      if (kbd_overflow && !ovf_prev_q) begin
        ext_f_q <= 1'b0;
        brk_f_q <= 1'b0;
        skip_q  <= '0;
      end

      if (kbd_overflow)  ovf_q <= 1'b1;
      else if (ovf_clr)  ovf_q <= 1'b0;
    end
  end

  assign kbd_rdn    = rdn_q;
  assign evt_valid  = evt_valid_q;
  assign evt_code   = evt_code_q;
  assign evt_ext    = evt_ext_q;
  assign evt_brk    = evt_brk_q;
  assign evt_mods   = evt_mods_q;
  assign ovf_sticky = ovf_q;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
module tb_ps2_kbd_ctrl;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic [3:0] mods;
  } evt_t;

  typedef struct {
    logic [7:0] b;
    logic       emit;
    evt_t       exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       clrn;
  logic       kbd_ready;
  logic [7:0] kbd_data;
  logic       kbd_overflow;
  logic       kbd_rdn;
  logic       evt_valid;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_brk;
  logic [3:0] evt_mods;
  logic       evt_ack;
  logic       ovf_sticky;
  logic       ovf_clr;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  // Bench-side FIFO: written by the stimulus, popped on the DUT read strobe
  logic [7:0] mem [0:1023];
  int         wr_ptr = 0;
  int         rd_ptr = 0;

  evt_t sb[$];
  vec_t tbl[$];

  assign kbd_ready = (wr_ptr != rd_ptr);
  assign kbd_data  = mem[rd_ptr[9:0]];

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!kbd_rdn && kbd_ready) rd_ptr <= rd_ptr + 1;

  ps2_kbd_ctrl #(
    .PAUSE_SKIP (7),
    .PAUSE_CODE (8'hE1)
  ) dut (
    .clk          (clk),
    .clrn         (clrn),
    .kbd_ready    (kbd_ready),
    .kbd_data     (kbd_data),
    .kbd_overflow (kbd_overflow),
    .kbd_rdn      (kbd_rdn),
    .evt_valid    (evt_valid),
    .evt_code     (evt_code),
    .evt_ext      (evt_ext),
    .evt_brk      (evt_brk),
    .evt_mods     (evt_mods),
    .evt_ack      (evt_ack),
    .ovf_sticky   (ovf_sticky),
    .ovf_clr      (ovf_clr)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    mem[wr_ptr[9:0]] = b;
    wr_ptr++;
  endtask

  function automatic evt_t mk(input logic [7:0] c, input logic e, input logic k, input logic [3:0] m);
    evt_t r;
    r.code = c; r.ext = e; r.brk = k; r.mods = m;
    return r;
  endfunction

  task automatic add(input logic [7:0] b, input logic emit, input logic [7:0] c,
                     input logic e, input logic k, input logic [3:0] m);
    vec_t v;
    v.b = b; v.emit = emit; v.exp = mk(c, e, k, m);
    tbl.push_back(v);
  endtask

  task automatic add0(input logic [7:0] b);
    add(b, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0);
  endtask

  task automatic compare_evt();
    evt_t got, exp;
    got = {evt_code, evt_ext, evt_brk, evt_mods};
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL evt_unexpected: got code=%h ext=%b brk=%b mods=%b expected no event",
               got.code, got.ext, got.brk, got.mods);
    end else begin
      exp = sb.pop_front();
      if (got !== exp) begin
        failures++;
        $display("FAIL evt: got code=%h ext=%b brk=%b mods=%b expected code=%h ext=%b brk=%b mods=%b",
                 got.code, got.ext, got.brk, got.mods, exp.code, exp.ext, exp.brk, exp.mods);
      end
    end
  endtask

  // Auto-acks events, comparing each with the scoreboard head, until the
  // FIFO is empty and no event has appeared for several cycles.
  task automatic drain(input string name, input int unsigned budget);
    int unsigned quiet = 0;
    int unsigned cyc = 0;
    while (quiet < 4 && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (evt_valid && !evt_ack) begin
        compare_evt();
        evt_ack = 1'b1;
        quiet = 0;
      end else begin
        evt_ack = 1'b0;
        if (!kbd_ready && !evt_valid) quiet++;
        else quiet = 0;
      end
    end
    evt_ack = 1'b0;
    if (quiet < 4) check({name, "_timeout"}, 32'(cyc), 32'(budget + 1));
    check({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic wait_valid(input string name, input int unsigned budget);
    int unsigned cyc = 0;
    while (!evt_valid && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    if (!evt_valid) check({name, "_wait_valid"}, 32'(evt_valid), 32'd1);
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {18'd0, kbd_rdn, evt_valid, evt_code, evt_ext, evt_brk, evt_mods, ovf_sticky},
          {18'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 1'b0});
  endtask

  initial begin
    int unsigned cyc;
    int unsigned rdn_low;
    int          level;

    clrn = 1'b0;
    kbd_overflow = 1'b0;
    evt_ack = 1'b0;
    ovf_clr = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    clrn = 1'b1;
    repeat (2) @(negedge clk);

    // Latency: ready seen in IDLE -> POP -> GAP -> EMIT, rdn low one cycle
    push_byte(8'h1C);
    cyc = 0;
    rdn_low = 0;
    while (!evt_valid && cyc < 10) begin
      @(negedge clk);
      cyc++;
      if (!kbd_rdn) rdn_low++;
    end
    check("latency_cycles", 32'(cyc), 32'd3);
    check("rdn_low_cycles", 32'(rdn_low), 32'd1);
    check("first_evt", {18'd0, evt_code, evt_ext, evt_brk, evt_mods}, {18'd0, 8'h1C, 1'b0, 1'b0, 4'h0});
    evt_ack = 1'b1;
    @(negedge clk);
    evt_ack = 1'b0;
    check("ack_clears_valid", 32'(evt_valid), 32'd0);

    // Backpressure: pending event blocks further pops
    push_byte(8'h1A);
    sb.push_back(mk(8'h1A, 1'b0, 1'b0, 4'h0));
    wait_valid("bp", 10);
    push_byte(8'h1B);
    push_byte(8'h21);
    push_byte(8'h22);
    rdn_low = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!kbd_rdn) rdn_low++;
    end
    check("bp_no_pop", 32'(rdn_low), 32'd0);
    check("bp_valid_held", 32'(evt_valid), 32'd1);
    level = wr_ptr - rd_ptr;
    check("bp_fifo_level", 32'(level), 32'd3);
    sb.push_back(mk(8'h1B, 1'b0, 1'b0, 4'h0));
    sb.push_back(mk(8'h21, 1'b0, 1'b0, 4'h0));
    sb.push_back(mk(8'h22, 1'b0, 1'b0, 4'h0));
    drain("bp", 200);

    // Main decode table: {byte, emits?, expected event}
    add(8'h12, 1, 8'h12, 0, 0, 4'h1);
    add(8'h1C, 1, 8'h1C, 0, 0, 4'h1);
    add0(8'hF0); add(8'h1C, 1, 8'h1C, 0, 1, 4'h1);
    add0(8'hF0); add(8'h12, 1, 8'h12, 0, 1, 4'h0);
    add0(8'hE0); add(8'h14, 1, 8'h14, 1, 0, 4'h2);
    add0(8'hE0); add0(8'hF0); add(8'h14, 1, 8'h14, 1, 1, 4'h0);
    add0(8'hE0); add0(8'h12);
    add(8'h1C, 1, 8'h1C, 0, 0, 4'h0);
    add(8'h58, 1, 8'h58, 0, 0, 4'h8);
    add(8'h58, 1, 8'h58, 0, 0, 4'h8);
    add0(8'hF0); add(8'h58, 1, 8'h58, 0, 1, 4'h8);
    add(8'h58, 1, 8'h58, 0, 0, 4'h0);
    add0(8'hE1); add0(8'h14); add0(8'h77); add0(8'hE1);
    add0(8'hF0); add0(8'h14); add0(8'hF0); add(8'h77, 1, 8'hE1, 0, 0, 4'h0);
    add0(8'hAA); add0(8'hFA);
    add0(8'hE0); add0(8'hAA); add(8'h1C, 1, 8'h1C, 0, 0, 4'h0);
    add0(8'hF0); add0(8'hFE); add(8'h1C, 1, 8'h1C, 0, 0, 4'h0);
    add(8'h11, 1, 8'h11, 0, 0, 4'h4);
    add0(8'hE0); add(8'h11, 1, 8'h11, 1, 0, 4'h4);
    add0(8'hF0); add(8'h11, 1, 8'h11, 0, 1, 4'h4);
    add0(8'hE0); add0(8'hF0); add(8'h11, 1, 8'h11, 1, 1, 4'h0);
    add(8'h59, 1, 8'h59, 0, 0, 4'h1);
    add(8'h14, 1, 8'h14, 0, 0, 4'h3);
    add0(8'hF0); add(8'h59, 1, 8'h59, 0, 1, 4'h2);
    add0(8'hF0); add(8'h14, 1, 8'h14, 0, 1, 4'h0);
    add0(8'hE0); add0(8'h59); add0(8'h00); add0(8'hFF);
    add0(8'hE0); add0(8'hE1);
    for (int i = 0; i < 6; i++) add0(8'h1C);
    add(8'h1C, 1, 8'hE1, 0, 0, 4'h0);
    add(8'h1C, 1, 8'h1C, 0, 0, 4'h0);

    for (int unsigned i = 0; i < tbl.size(); i++) begin
      push_byte(tbl[i].b);
      if (tbl[i].emit) sb.push_back(tbl[i].exp);
    end
    drain("table", 3000);

    // Overflow: sticky flag, set-wins, resync of prefixes, mods kept
    push_byte(8'h12);
    sb.push_back(mk(8'h12, 0, 0, 4'h1));
    drain("ovf_pre", 100);
    push_byte(8'hE0);
    repeat (6) @(negedge clk);
    kbd_overflow = 1'b1;
    @(negedge clk);
    kbd_overflow = 1'b0;
    check("ovf_set", 32'(ovf_sticky), 32'd1);
    push_byte(8'h1C);
    sb.push_back(mk(8'h1C, 0, 0, 4'h1));
    drain("ovf_resync_ext", 100);
    check("ovf_held", 32'(ovf_sticky), 32'd1);
    push_byte(8'hE1);
    repeat (6) @(negedge clk);
    kbd_overflow = 1'b1;
    ovf_clr = 1'b1;
    @(negedge clk);
    kbd_overflow = 1'b0;
    ovf_clr = 1'b0;
    check("ovf_set_wins", 32'(ovf_sticky), 32'd1);
    push_byte(8'h1D);
    sb.push_back(mk(8'h1D, 0, 0, 4'h1));
    drain("ovf_resync_skip", 100);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("ovf_clr", 32'(ovf_sticky), 32'd0);

    // Reset mid-EMIT with shift held: everything returns to reset values
    push_byte(8'h1C);
    sb.push_back(mk(8'h1C, 0, 0, 4'h1));
    wait_valid("rst", 10);
    compare_evt();
    clrn = 1'b0;
    #1;
    check_reset_outputs("reset_mid_emit");
    @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);
    push_byte(8'h1C);
    sb.push_back(mk(8'h1C, 0, 0, 4'h0));
    drain("post_reset", 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
